// File: rtl/protobuf_pkg.sv
// Shared protobuf wire-format constants and types.
// Used by the varint decoder and the downstream field decoder.
package protobuf_pkg;

    localparam int unsigned MAX_VARINT_BYTES = 10;
    localparam int unsigned VARINT_VALUE_W   = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DISCARD
    } varint_state_t;

    function automatic logic VARINT_CONT(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/protobuf_varint_decoder.sv
// Reassembles base-128 varints from a wire byte stream into zero-extended values,
// flagging overlong varints and varints cut short by end of message.
module protobuf_varint_decoder
    import protobuf_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_VARINT_BYTES,
    parameter int unsigned VALUE_W   = VARINT_VALUE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    output logic [VALUE_W-1:0] out_value,
    output logic [3:0]         out_nbytes,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err_overlong,
    output logic               err_truncated
);

    // Lanes are written into a vector wide enough for every byte, then the
    // bits at or above VALUE_W are dropped by the final slice.
    localparam int unsigned LanesW = 7 * MAX_BYTES;
    localparam int unsigned WideW  = (LanesW > VALUE_W) ? LanesW : VALUE_W;
    localparam int unsigned IdxW   = $clog2(WideW);

    varint_state_t      state_q, state_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [3:0]         count_q, count_d;
    logic [VALUE_W-1:0] out_value_q, out_value_d;
    logic [3:0]         out_nbytes_q, out_nbytes_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               err_overlong_q, err_overlong_d;
    logic               err_truncated_q, err_truncated_d;

    logic               accept;
    logic               cont;
    logic [IdxW-1:0]    lane_lsb;
    logic [WideW-1:0]   wide;
    logic [VALUE_W-1:0] merged;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cont     = VARINT_CONT(in_data);

    always_comb begin
        lane_lsb = IdxW'(7 * count_q);
        wide     = WideW'(acc_q);
        wide[lane_lsb +: 7] = in_data[6:0];
        merged   = wide[VALUE_W-1:0];
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        count_d         = count_q;
        out_value_d     = out_value_q;
        out_nbytes_d    = out_nbytes_q;
        out_last_d      = out_last_q;
        out_valid_d     = out_valid_q && !out_ready;
        err_overlong_d  = 1'b0;
        err_truncated_d = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (!cont) begin
                        out_valid_d  = 1'b1;
                        out_value_d  = merged;
                        out_nbytes_d = count_q + 4'd1;
                        out_last_d   = in_last;
                        acc_d        = '0;
                        count_d      = '0;
                        state_d      = IDLE;
                    end else if (in_last) begin
                        err_truncated_d = 1'b1;
                        acc_d           = '0;
                        count_d         = '0;
                        state_d         = IDLE;
                    end else if (count_q == 4'(MAX_BYTES - 1)) begin
                        err_overlong_d = 1'b1;
                        acc_d          = '0;
                        count_d        = '0;
                        state_d        = DISCARD;
                    end else begin
                        acc_d   = merged;
                        count_d = count_q + 4'd1;
                        state_d = ACCUM;
                    end
                end
                DISCARD: begin
                    if (!cont || in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            count_q         <= '0;
            out_value_q     <= '0;
            out_nbytes_q    <= '0;
            out_last_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            err_overlong_q  <= 1'b0;
            err_truncated_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            count_q         <= count_d;
            out_value_q     <= out_value_d;
            out_nbytes_q    <= out_nbytes_d;
            out_last_q      <= out_last_d;
            out_valid_q     <= out_valid_d;
            err_overlong_q  <= err_overlong_d;
            err_truncated_q <= err_truncated_d;
        end
    end

    assign out_value     = out_value_q;
    assign out_nbytes    = out_nbytes_q;
    assign out_last      = out_last_q;
    assign out_valid     = out_valid_q;
    assign err_overlong  = err_overlong_q;
    assign err_truncated = err_truncated_q;

endmodule

// File: tb/tb_protobuf_varint_decoder.sv
// Scoreboard bench for protobuf_varint_decoder: directed byte streams with
// hand-computed results checked by an independent output monitor.
module tb_protobuf_varint_decoder;
    import protobuf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [63:0] out_value;
    logic [3:0]  out_nbytes;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        err_overlong;
    logic        err_truncated;

    protobuf_varint_decoder #(
        .MAX_BYTES(10),
        .VALUE_W  (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .out_value    (out_value),
        .out_nbytes   (out_nbytes),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_overlong (err_overlong),
        .err_truncated(err_truncated)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] value;
        logic [3:0]  nbytes;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   ovl_seen = 0;
    int   trn_seen = 0;
    int   ovl_exp = 0;
    int   trn_exp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [63:0] v, input logic [3:0] n, input logic l);
        exp_t e;
        e.value  = v;
        e.nbytes = n;
        e.last   = l;
        sb_q.push_back(e);
    endtask

    // Monitor: a result visible with out_ready high at negedge transfers on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_overlong)  ovl_seen++;
                if (err_truncated) trn_seen++;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got value 0x%0h, expected none",
                                 out_value);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("value",  out_value,         mon_e.value);
                        check("nbytes", 64'(out_nbytes),   64'(mon_e.nbytes));
                        check("last",   64'(out_last),     64'(mon_e.last));
                    end
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_out_valid",  64'(out_valid),     64'd0);
        check("reset_out_value",  out_value,          64'd0);
        check("reset_out_nbytes", 64'(out_nbytes),    64'd0);
        check("reset_errs",       64'({err_overlong, err_truncated}), 64'd0);
        check("reset_in_ready",   64'(in_ready),      64'd1);

        // 1: 0x96 0x01 -> 150, one cycle after the final beat
        send(8'h96, 1'b0);
        push(64'd150, 4'd2, 1'b0);
        send(8'h01, 1'b0);
        check("t1_latency", 64'(out_valid), 64'd1);
        idle(2);

        // 2: back-to-back 8 then 150, last flagged on final byte
        push(64'd8, 4'd1, 1'b0);
        send(8'h08, 1'b0);
        send(8'h96, 1'b0);
        push(64'd150, 4'd2, 1'b1);
        send(8'h01, 1'b1);
        idle(2);

        // 3: stall with result held, then release with a pending byte
        out_ready = 1'b0;
        push(64'd5, 4'd1, 1'b0);
        send(8'h05, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_value", out_value,      64'd5);
            check("t3_in_ready",   64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(64'd7, 4'd1, 1'b0);
        send(8'h07, 1'b0);
        check("t3_no_bubble_valid", 64'(out_valid), 64'd1);
        check("t3_no_bubble_value", out_value,      64'd7);
        idle(2);

        // 4: maximal 10-byte varint
        for (int i = 0; i < 9; i++) send(8'hFF, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
        send(8'h01, 1'b0);
        idle(2);

        // 5: overlong, discard until a terminator, then resume
        for (int i = 0; i < 10; i++) send(8'hFF, 1'b0);
        ovl_exp++;
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        push(64'd5, 4'd1, 1'b0);
        send(8'h05, 1'b0);
        idle(2);

        // 6: truncation in IDLE and in ACCUM, then a clean varint
        send(8'h80, 1'b1);
        trn_exp++;
        check("t6_no_result", 64'(out_valid), 64'd0);
        send(8'h96, 1'b0);
        send(8'h80, 1'b1);
        trn_exp++;
        push(64'd3, 4'd1, 1'b0);
        send(8'h03, 1'b0);
        idle(2);

        // 6b: reset discards a partial varint
        send(8'h96, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(64'd5, 4'd1, 1'b0);
        send(8'h05, 1'b0);
        idle(3);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        check("sb_drained",     64'(sb_q.size()), 64'd0);
        check("overlong_count", 64'(ovl_seen),    64'(ovl_exp));
        check("truncated_count", 64'(trn_seen),   64'(trn_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
